// File: rtl/if_stage.sv
// if_stage: instruction fetch with single-outstanding imem handshake, one-entry skid buffer and IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    logic [1:0]  st;
    logic [31:0] fetch_pc, req_pc, buf_pc, buf_instr;
    logic        buf_valid, rsp_direct, rsp, accept;
    always_comb begin
        rsp_direct = !id_valid || !stall;
        rsp        = (st == WAIT) && imem_rvalid;
        imem_req   = !rst && !redirect_valid && !buf_valid && ((st == IDLE) || (rsp && rsp_direct));
        accept     = imem_req && imem_ready;
    end
    assign imem_addr = fetch_pc;
    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            st        <= IDLE;
            buf_valid <= 1'b0;
            buf_pc    <= 32'd0;
            buf_instr <= NOP_INSTR;
            id_valid  <= 1'b0;
            id_pc     <= 32'd0;
            id_instr  <= NOP_INSTR;
        end else if (redirect_valid) begin
            // a request still in flight must have its response swallowed in DRAIN
            fetch_pc  <= {redirect_pc[31:2], 2'b00};
            st        <= (st == IDLE || imem_rvalid) ? IDLE : DRAIN;
            buf_valid <= 1'b0;
            id_valid  <= 1'b0;
            id_instr  <= NOP_INSTR;
        end else begin
            if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            st <= accept ? WAIT : (st != IDLE && !imem_rvalid) ? st : IDLE;
            if (rsp_direct) begin
                id_valid  <= buf_valid || rsp;
                id_pc     <= buf_valid ? buf_pc : rsp ? req_pc : id_pc;
                id_instr  <= buf_valid ? buf_instr : rsp ? imem_rdata : NOP_INSTR;
                buf_valid <= 1'b0;
            end else if (rsp) begin
                buf_valid <= 1'b1;
                buf_pc    <= req_pc;
                buf_instr <= imem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed table, corner sequences and randomized run against a fetch-order reference model
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;
    int errors = 0;
    int checks = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    int          cnt = 0;
    int          mem_lat = 1;
    logic        clr_on_rst = 1'b0;
    if_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        imem_rvalid    = pend && cnt == 0;
        imem_rdata     = imem_rvalid ? f(paddr) : $urandom;
        #1;
    endtask
    task automatic cyc_end();
        logic acc, rvd, r;
        logic [31:0] a;
        acc = imem_req && imem_ready;
        rvd = imem_rvalid;
        r   = rst;
        a   = imem_addr;
        @(posedge clk);
        if (rvd) pend = 1'b0;
        else if (pend && cnt > 0) cnt--;
        if (r && clr_on_rst) pend = 1'b0;
        if (acc) begin
            chk("single_outstanding", {31'd0, pend}, 32'd0);
            pend  = 1'b1;
            paddr = a;
            cnt   = mem_lat - 1;
        end
        @(negedge clk);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b0);
            cyc_end();
        end
    endtask
    task automatic wait_id(input logic [31:0] exp_pc, input string nm);
        int n;
        n = 0;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        while (!id_valid && n < 20) begin
            cyc_end();
            drive(1'b0, 1'b0, 32'd0, 1'b1);
            n++;
        end
        chk({nm, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({nm, "_pc"}, id_pc, exp_pc);
        chk({nm, "_instr"}, id_instr, f(exp_pc));
    endtask
    typedef struct {
        logic        s;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[17];
    initial begin
        logic [31:0] exp_fetch, exp_id, prev_pc, prev_addr, rpc;
        logic        prev_hold, prev_unacc, s, rv, rdy, cons;
        int          consumed;
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0C};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h1C};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h1C};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b0, 32'h1C};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 32'h20};
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_addr", imem_addr, 32'd0);
        cyc_end();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].s, 1'b0, 32'd0, tbl[i].rdy);
            chk($sformatf("t%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("t%0d_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].v});
            chk($sformatf("t%0d_pc", i), id_pc, tbl[i].pc);
            chk($sformatf("t%0d_instr", i), id_instr, tbl[i].v ? f(tbl[i].pc) : NOP);
            chk($sformatf("t%0d_opcode", i), {25'd0, id_opcode}, {25'd0, tbl[i].v ? f(tbl[i].pc) & 32'h7F : NOP & 32'h7F});
            cyc_end();
        end
        idle(3);
        // redirect while a slow response is outstanding
        mem_lat = 3;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("r1_req", {31'd0, imem_req}, 32'd1);
        cyc_end();
        drive(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        chk("r1_redir_req", {31'd0, imem_req}, 32'd0);
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("r1_valid", {31'd0, id_valid}, 32'd0);
        chk("r1_nop", id_instr, NOP);
        chk("r1_drain_req", {31'd0, imem_req}, 32'd0);
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("r1_drain_req2", {31'd0, imem_req}, 32'd0);
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("r1_new_req", {31'd0, imem_req}, 32'd1);
        chk("r1_new_addr", imem_addr, 32'h0000_0100);
        chk("r1_still_invalid", {31'd0, id_valid}, 32'd0);
        cyc_end();
        wait_id(32'h0000_0100, "r1_first");
        cyc_end();
        idle(5);
        // redirect and stall together with the buffer holding an instruction
        mem_lat = 1;
        wait_id(32'h0000_0108, "r2_pre");
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("r2_stall_req", {31'd0, imem_req}, 32'd0);
        cyc_end();
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("r2_buf_req", {31'd0, imem_req}, 32'd0);
        chk("r2_hold_pc", id_pc, 32'h0000_0108);
        drive(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        chk("r2_redir_req", {31'd0, imem_req}, 32'd0);
        cyc_end();
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("r2_valid", {31'd0, id_valid}, 32'd0);
        chk("r2_nop", id_instr, NOP);
        chk("r2_req", {31'd0, imem_req}, 32'd1);
        chk("r2_addr", imem_addr, 32'h0000_0200);
        cyc_end();
        wait_id(32'h0000_0200, "r2_first");
        cyc_end();
        idle(5);
        // address wrap at the top of the address space
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("w_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("w_req0", {31'd0, imem_req}, 32'd1);
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("w_addr1", imem_addr, 32'h0000_0000);
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("w_id0", id_pc, 32'hFFFF_FFFC);
        chk("w_instr0", id_instr, f(32'hFFFF_FFFC));
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("w_id1", id_pc, 32'h0000_0000);
        chk("w_valid1", {31'd0, id_valid}, 32'd1);
        cyc_end();
        idle(5);
        // reset mid-request; the stale response lands right after release
        mem_lat = 2;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("rw_req", {31'd0, imem_req}, 32'd1);
        cyc_end();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("rw_rst_req", {31'd0, imem_req}, 32'd0);
        cyc_end();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("rw_stale_seen", {31'd0, imem_rvalid}, 32'd1);
        chk("rw_req2", {31'd0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, 32'd0);
        chk("rw_valid0", {31'd0, id_valid}, 32'd0);
        cyc_end();
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("rw_valid1", {31'd0, id_valid}, 32'd0);
        cyc_end();
        wait_id(32'd0, "rw_first");
        cyc_end();
        // randomized run against the fetch-order model
        clr_on_rst = 1'b1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        cyc_end();
        rst = 1'b0;
        exp_fetch = 32'd0;
        exp_id = 32'd0;
        prev_hold = 1'b0;
        prev_unacc = 1'b0;
        prev_pc = 32'd0;
        prev_addr = 32'd0;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom % 10) < 3;
            rv = ($urandom % 20) == 0;
            rpc = $urandom;
            rdy = ($urandom % 10) < 7;
            rst = ($urandom % 200) == 0;
            mem_lat = 1 + int'($urandom % 3);
            drive(s, rv, rpc, rdy);
            if (prev_hold) begin
                chk("rnd_hold_valid", {31'd0, id_valid}, 32'd1);
                chk("rnd_hold_pc", id_pc, prev_pc);
            end
            if (prev_unacc && !rv && !rst) begin
                chk("rnd_req_stable", {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            chk("rnd_instr", id_instr, id_valid ? f(id_pc) : NOP);
            chk("rnd_slices", {15'd0, id_funct7, id_funct3, id_opcode},
                {15'd0, id_instr[31:25], id_instr[14:12], id_instr[6:0]});
            if (rv || rst) chk("rnd_req_blocked", {31'd0, imem_req}, 32'd0);
            if (imem_req && imem_ready) chk("rnd_fetch_addr", imem_addr, exp_fetch);
            cons = id_valid && !s && !rv && !rst;
            if (cons) begin
                chk("rnd_order", id_pc, exp_id);
                consumed++;
            end
            prev_hold = id_valid && s && !rv && !rst;
            prev_pc = id_pc;
            prev_unacc = imem_req && !imem_ready;
            prev_addr = imem_addr;
            if (rst) begin
                exp_fetch = 32'd0;
                exp_id = 32'd0;
            end else if (rv) begin
                exp_fetch = {rpc[31:2], 2'b00};
                exp_id = {rpc[31:2], 2'b00};
            end else begin
                if (imem_req && imem_ready) exp_fetch = exp_fetch + 32'd4;
                if (cons) exp_id = exp_id + 32'd4;
            end
            cyc_end();
        end
        rst = 1'b0;
        chk("rnd_progress", {31'd0, consumed > 200}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register.
- Holds the fetch PC and issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake.
- Buffers one returned instruction when decode stalls, and presents opcode/funct3/funct7 to the pipelined control unit.
- Consumes the stall and flush decisions: stall holds IF/ID; redirect (branch/jump flush) discards in-flight work and restarts at a new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented when IF/ID holds no valid instruction (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; word aligned.
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  response valid; earliest 1 cycle after accept.
- imem_rdata  input  32  instruction word.
- stall  input  1  decode cannot accept; hold IF/ID.
- redirect_valid  input  1  flush; restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0 internally.
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  32  PC of IF/ID instruction.
- id_instr  output  32  IF/ID instruction (NOP_INSTR when invalid).
- id_opcode  output  7  id_instr[6:0].
- id_funct3  output  3  id_instr[14:12].
- id_funct7  output  7  id_instr[31:25].

Behaviour:
- Reset: fetch_pc=RESET_PC, FSM=IDLE, buffer empty, id_valid=0, id_pc=0, id_instr=NOP_INSTR. imem_req=0 during the reset cycle.
- FSM states:
  - IDLE: no outstanding request.
  - WAIT: one request outstanding.
  - DRAIN: outstanding request whose response must be discarded.
- imem_req (combinational) = !rst && !redirect_valid && !buf_valid && (IDLE || (WAIT && imem_rvalid && rsp_direct)).
  - rsp_direct = (!id_valid || !stall): the response goes straight into IF/ID.
- imem_addr = fetch_pc.
- Request accept (imem_req && imem_ready): req_pc<=fetch_pc; fetch_pc<=fetch_pc+4, mod 2^32, so 32'hFFFF_FFFC wraps to 0. FSM->WAIT.
- Unaccepted request: imem_req and imem_addr hold stable until ready, unless a redirect occurs.
- IF/ID consumed each cycle id_valid && !stall. IF/ID next-load priority:
  1. Buffer entry.
  2. Direct response.
  3. Otherwise id_valid<=0, id_instr<=NOP_INSTR, id_pc holds.
- Response in WAIT:
  - rsp_direct=1: IF/ID<={req_pc, imem_rdata}, id_valid<=1.
  - rsp_direct=0: buffer<={req_pc, imem_rdata}, buf_valid<=1.
  - FSM->IDLE, unless a new request is accepted in the same cycle (stays WAIT).
- Buffer drains into IF/ID on the first cycle stall=0.
- Request issue is suppressed while buf_valid=1. At most IF/ID + buffer + 0 outstanding when stalled.
- Throughput: 1 instruction/cycle with 1-cycle memory latency and no stall.
- Stall: id_valid, id_pc, id_instr unchanged; fetch continues until the buffer is full.
- Redirect (highest priority, overrides stall):
  - Same cycle: imem_req=0.
  - Next edge: fetch_pc<={redirect_pc[31:2],2'b00}, id_valid<=0, id_instr<=NOP_INSTR, buf_valid<=0.
  - FSM: WAIT without rvalid -> DRAIN; WAIT with rvalid -> IDLE, data dropped; IDLE stays IDLE; DRAIN stays DRAIN unless rvalid (-> IDLE).
  - First request to the new PC is issued the cycle after redirect, or the cycle after DRAIN exit.
- DRAIN: imem_req=0; on imem_rvalid, discard data and go to IDLE.
- imem_rvalid in IDLE (e.g. stale response after reset mid-operation) is ignored.
- Outputs id_opcode/funct3/funct7 are pure slices of the id_instr register; no extra latency.

Test Plan:
- Reset, then ready=1 with rvalid every cycle 1 cycle after accept, stall=0 -> imem_addr 0,4,8,C on consecutive cycles; id_pc 0,4,8 on consecutive cycles with id_valid=1; id_opcode matches rdata[6:0].
- Stall held 3 cycles while PC 8 is in IF/ID -> IF/ID holds PC 8; PC C response goes to buffer; imem_req=0 while buffer full. On release: PC C in IF/ID next cycle, then PC 10; no instruction lost or duplicated.
- redirect_valid with redirect_pc=32'h0000_0103 while WAIT and rvalid low -> id_valid=0 and id_instr=32'h0000_0013 next cycle; late response discarded; next imem_addr=32'h0000_0100.
- Redirect and stall asserted together with buffer full -> buffer and IF/ID cleared; fetch restarts at redirect_pc; stall ignored for that cycle.
- Fetch from 32'hFFFF_FFFC -> next imem_addr=32'h0000_0000.
- rst asserted in WAIT, rvalid arrives the cycle after reset release -> response ignored; first request to RESET_PC; id_valid stays 0 until its response.
